// File: rtl/can_rx_destuff_crc.sv
// can_rx_destuff_crc: receive-side CAN bit destuffer and CRC-15 checker.
// Takes one sampled bus bit per sample strobe and drops stuff bits.
// Runs CRC-15 over every destuffed bit.
// Reports a pass/fail verdict when the framer asks for it.
// Optional build macro: CAN_RX_STUFF_CHECK_EN. When it is defined, stuff
// violations are detected and the ERR state is built.
module can_rx_destuff_crc #(
  parameter int unsigned      CRC_W     = 15,
  parameter logic [CRC_W-1:0] CRC_POLY  = 15'h4599,
  parameter int unsigned      STUFF_LEN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             rx_bit,
  input  logic             rx_start,
  input  logic             crc_chk,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             stuff_err,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [CRC_W-1:0] crc_val
);

  localparam int unsigned     CNT_W   = $clog2(STUFF_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);

`ifdef CAN_RX_STUFF_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, HOLD, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
`endif

  state_t           state, state_n;
  logic             start_d;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last_bit, last_bit_n;
  logic             take, pending, stuff_bad, accept, chk, start_edge;
  logic [CRC_W-1:0] crc_upd, crc_eff, crc_n;
  logic             bit_out_n, bit_valid_n, stuff_err_n, crc_ok_n, crc_err_n;

  // Decode the current strobe: stuff bit, violation, data bit, or verdict request.
  always_comb begin
    // start_d resets high, so rx_start held through reset is not a start edge.
    start_edge = rx_start & ~start_d;
    pending    = (cnt == RUN_MAX);
    take       = (state == RUN) && rx_start && sample_en;
    accept     = take && !pending;
`ifdef CAN_RX_STUFF_CHECK_EN
    stuff_bad  = take && pending && (rx_bit == last_bit);
`else
    stuff_bad  = 1'b0;
`endif
    crc_upd    = {crc_val[CRC_W-2:0], 1'b0} ^
                 ((rx_bit ^ crc_val[CRC_W-1]) ? CRC_POLY : '0);
    // A verdict requested together with a data bit uses the updated CRC.
    crc_eff    = accept ? crc_upd : crc_val;
    chk        = (state == RUN) && rx_start && crc_chk && !stuff_bad;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic; dropping rx_start returns to IDLE from any state.
  always_comb begin
    state_n = state;
    if (!rx_start) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start_edge) state_n = RUN;
        RUN: begin
          if (chk) state_n = HOLD;
`ifdef CAN_RX_STUFF_CHECK_EN
          if (stuff_bad) state_n = ERR;
`endif
        end
        default: state_n = state;
      endcase
    end
  end

  // Output and datapath next values: pulses, run count, last bit, and CRC.
  always_comb begin
    bit_out_n   = accept ? rx_bit : bit_out;
    bit_valid_n = accept;
    stuff_err_n = stuff_bad;
    crc_ok_n    = chk && (crc_eff == '0);
    crc_err_n   = chk && (crc_eff != '0);
    last_bit_n  = take ? rx_bit : last_bit;
    cnt_n       = cnt;
    crc_n       = crc_val;
    if (state_n == IDLE) begin
      cnt_n = '0;
      crc_n = '0;
    end else if (take && pending) begin
      cnt_n = CNT_W'(1);
    end else if (accept) begin
      crc_n = crc_upd;
      if (cnt != '0 && rx_bit == last_bit) cnt_n = cnt + CNT_W'(1);
      else                                 cnt_n = CNT_W'(1);
    end
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_d   <= 1'b1;
      cnt       <= '0;
      last_bit  <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      stuff_err <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      crc_val   <= '0;
    end else begin
      start_d   <= rx_start;
      cnt       <= cnt_n;
      last_bit  <= last_bit_n;
      bit_out   <= bit_out_n;
      bit_valid <= bit_valid_n;
      stuff_err <= stuff_err_n;
      crc_ok    <= crc_ok_n;
      crc_err   <= crc_err_n;
      crc_val   <= crc_n;
    end
  end

endmodule

// File: tb/tb_can_rx_destuff_crc.sv
// Directed testbench for can_rx_destuff_crc.
module tb_can_rx_destuff_crc;
  logic        clk = 1'b0;
  logic        rst, sample_en, rx_bit, rx_start, crc_chk;
  logic        bit_out, bit_valid, stuff_err, crc_ok, crc_err;
  logic [14:0] crc_val;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        g_valid, g_out, g_serr, g_ok, g_err, g_next;
  logic [14:0] g_crc;

  can_rx_destuff_crc #(.CRC_W(15), .CRC_POLY(15'h4599), .STUFF_LEN(5)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .rx_bit(rx_bit),
    .rx_start(rx_start), .crc_chk(crc_chk), .bit_out(bit_out),
    .bit_valid(bit_valid), .stuff_err(stuff_err), .crc_ok(crc_ok),
    .crc_err(crc_err), .crc_val(crc_val)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and capture the registered response.
  // Then idle one cycle and note whether any pulse is still high.
  task automatic pulse(input logic s, input logic b, input logic c);
    sample_en = s; rx_bit = b; crc_chk = c;
    @(posedge clk); #1;
    sample_en = 1'b0; crc_chk = 1'b0;
    g_valid = bit_valid; g_out = bit_out; g_serr = stuff_err;
    g_ok = crc_ok; g_err = crc_err; g_crc = crc_val;
    @(posedge clk); #1;
    g_next = bit_valid | stuff_err | crc_ok | crc_err;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b0; rx_start = 1'b0; sample_en = 1'b0; crc_chk = 1'b0; rx_bit = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(1);
    total_cnt++;
    if ({bit_out, bit_valid, stuff_err, crc_ok, crc_err} !== 5'b0)
      $display("FAIL reset_outs: got %b want 00000", {bit_out, bit_valid, stuff_err, crc_ok, crc_err});
    else pass_cnt++;
    total_cnt++;
    if (crc_val !== 15'h0) $display("FAIL reset_crc: got %h want 0000", crc_val); else pass_cnt++;
    // Mid-frame reset after 3 bits.
    rx_start = 1'b1; idle(1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (g_crc !== 15'h4599) $display("FAIL pre_reset_crc: got %h want 4599", g_crc); else pass_cnt++;
    pulse(1'b1, 1'b1, 1'b0);
    rst = 1'b0; sample_en = 1'b1; rx_bit = 1'b0; crc_chk = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0; crc_chk = 1'b0;
    total_cnt++;
    if ({bit_out, bit_valid, stuff_err, crc_ok, crc_err} !== 5'b0 || crc_val !== 15'h0)
      $display("FAIL midframe_reset: got outs=%b crc=%h want outs=00000 crc=0000",
               {bit_out, bit_valid, stuff_err, crc_ok, crc_err}, crc_val);
    else pass_cnt++;
    rst = 1'b1; idle(1);
    // rx_start still high: no fresh edge, so no frame.
    pulse(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (g_valid !== 1'b0 || g_crc !== 15'h0)
      $display("FAIL reset_needs_edge: got valid=%b crc=%h want valid=0 crc=0000", g_valid, g_crc);
    else pass_cnt++;
    rx_start = 1'b0; idle(2);
  endtask

  task automatic test_stuff_removal;
    logic [0:6] bits = 7'b0000010;
    logic [0:6] exp_v = 7'b1111101;
    int unsigned nvalid = 0;
    rx_start = 1'b1; idle(1);
    for (int unsigned i = 0; i < 7; i++) begin
      pulse(1'b1, bits[i], 1'b0);
      if (g_valid === 1'b1) nvalid++;
      total_cnt++;
      if (g_valid !== exp_v[i] || (exp_v[i] && g_out !== 1'b0) || g_serr !== 1'b0)
        $display("FAIL destuff_bit%0d: got valid=%b out=%b serr=%b want valid=%b out=0 serr=0",
                 i, g_valid, g_out, g_serr, exp_v[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (nvalid != 6) $display("FAIL destuff_count: got %0d want 6", nvalid); else pass_cnt++;
    total_cnt++;
    if (g_crc !== 15'h0) $display("FAIL destuff_crc: got %h want 0000", g_crc); else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (g_ok !== 1'b1 || g_err !== 1'b0)
      $display("FAIL destuff_verdict: got ok=%b err=%b want ok=1 err=0", g_ok, g_err);
    else pass_cnt++;
    total_cnt++;
    if (g_next !== 1'b0) $display("FAIL ok_one_cycle: got %b want 0", g_next); else pass_cnt++;
    rx_start = 1'b0; idle(2);
  endtask

  task automatic test_stuff_violation;
    rx_start = 1'b1; idle(1);
    for (int unsigned i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
`ifdef CAN_RX_STUFF_CHECK_EN
    total_cnt++;
    if (g_serr !== 1'b1 || g_valid !== 1'b0)
      $display("FAIL stuff_violation: got serr=%b valid=%b want serr=1 valid=0", g_serr, g_valid);
    else pass_cnt++;
    total_cnt++;
    if (g_next !== 1'b0) $display("FAIL serr_one_cycle: got %b want 0", g_next); else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (g_ok !== 1'b0 || g_err !== 1'b0)
      $display("FAIL err_state_chk: got ok=%b err=%b want ok=0 err=0", g_ok, g_err);
    else pass_cnt++;
`else
    total_cnt++;
    if (g_serr !== 1'b0 || g_valid !== 1'b0)
      $display("FAIL stuff_drop: got serr=%b valid=%b want serr=0 valid=0", g_serr, g_valid);
    else pass_cnt++;
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (g_valid !== 1'b1 || g_out !== 1'b0)
      $display("FAIL after_drop: got valid=%b out=%b want valid=1 out=0", g_valid, g_out);
    else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (g_ok !== 1'b1 || g_err !== 1'b0)
      $display("FAIL drop_verdict: got ok=%b err=%b want ok=1 err=0", g_ok, g_err);
    else pass_cnt++;
`endif
    rx_start = 1'b0; idle(2);
  endtask

  task automatic test_crc_fail;
    rx_start = 1'b1; idle(1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (g_crc !== 15'h4599 || g_valid !== 1'b1 || g_out !== 1'b1)
      $display("FAIL crc_fail_val: got crc=%h valid=%b out=%b want crc=4599 valid=1 out=1",
               g_crc, g_valid, g_out);
    else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (g_err !== 1'b1 || g_ok !== 1'b0)
      $display("FAIL crc_fail_verdict: got ok=%b err=%b want ok=0 err=1", g_ok, g_err);
    else pass_cnt++;
    total_cnt++;
    if (g_next !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", g_next); else pass_cnt++;
    // HOLD ignores strobes and keeps crc_val.
    pulse(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (g_valid !== 1'b0 || g_err !== 1'b0 || g_ok !== 1'b0 || g_crc !== 15'h4599)
      $display("FAIL hold_frozen: got valid=%b ok=%b err=%b crc=%h want 0 0 0 4599",
               g_valid, g_ok, g_err, g_crc);
    else pass_cnt++;
    rx_start = 1'b0; idle(2);
  endtask

  task automatic test_crc_pass;
    logic [0:16] seq = 17'b01_100010110011001;
    rx_start = 1'b1; idle(1);
    for (int unsigned i = 0; i < 16; i++) pulse(1'b1, seq[i], 1'b0);
    pulse(1'b1, seq[16], 1'b1);
    total_cnt++;
    if (g_crc !== 15'h0 || g_valid !== 1'b1)
      $display("FAIL crc_pass_val: got crc=%h valid=%b want crc=0000 valid=1", g_crc, g_valid);
    else pass_cnt++;
    total_cnt++;
    if (g_ok !== 1'b1 || g_err !== 1'b0)
      $display("FAIL crc_pass_verdict: got ok=%b err=%b want ok=1 err=0", g_ok, g_err);
    else pass_cnt++;
    rx_start = 1'b0; idle(2);
  endtask

  task automatic test_abort_oneshot;
    rx_start = 1'b1; idle(1);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    // Drop rx_start together with a strobe and a check request.
    rx_start = 1'b0;
    pulse(1'b1, 1'b1, 1'b1);
    total_cnt++;
    if ({g_valid, g_serr, g_ok, g_err} !== 4'b0 || g_crc !== 15'h0)
      $display("FAIL abort: got pulses=%b crc=%h want pulses=0000 crc=0000",
               {g_valid, g_serr, g_ok, g_err}, g_crc);
    else pass_cnt++;
    rx_start = 1'b1; idle(1);
    pulse(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (g_valid !== 1'b1) $display("FAIL restart: got valid=%b want 1", g_valid); else pass_cnt++;
    pulse(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (g_ok !== 1'b1) $display("FAIL restart_ok: got ok=%b want 1", g_ok); else pass_cnt++;
    // rx_start stays high in HOLD: no new frame.
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (g_ok !== 1'b0 || g_err !== 1'b0 || g_crc !== 15'h0)
      $display("FAIL oneshot: got ok=%b err=%b crc=%h want 0 0 0000", g_ok, g_err, g_crc);
    else pass_cnt++;
    rx_start = 1'b0; idle(1);
    rx_start = 1'b1; idle(1);
    pulse(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (g_valid !== 1'b1 || g_crc !== 15'h4599)
      $display("FAIL retoggle: got valid=%b crc=%h want valid=1 crc=4599", g_valid, g_crc);
    else pass_cnt++;
    rx_start = 1'b0; idle(2);
  endtask

  initial begin
    test_reset();
    test_stuff_removal();
    test_stuff_violation();
    test_crc_fail();
    test_crc_pass();
    test_abort_oneshot();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/can_rx_destuff_crc.md
# can_rx_destuff_crc

Receive-side bit destuffer and CRC-15 checker for the CAN controller, the counterpart of the transmit-side CRC enable path. It sits between the bit-timing sampler and the receive framer. It takes one sampled bus bit per sample strobe and removes stuff bits, flagging stuff violations. It runs the CAN CRC-15 over every destuffed bit from SOF through the received CRC field and reports pass/fail when the framer requests the check.

## Interface
- CRC_W, 15, CRC register width
- CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial (x^15 term implicit)
- STUFF_LEN, 5, run length of equal bits after which a stuff bit follows
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- sample_en  input  1  one-cycle strobe at the bit sample point
- rx_bit  input  1  sampled bus level, 1 = recessive; valid when sample_en=1
- rx_start  input  1  level from framer; high from SOF sample through end of CRC field
- crc_chk  input  1  one-cycle strobe; framer requests the CRC verdict
- bit_out  output  1  destuffed bit
- bit_valid  output  1  one-cycle pulse, bit_out valid
- stuff_err  output  1  one-cycle pulse, stuff rule violated
- crc_ok  output  1  one-cycle pulse, CRC residual is zero
- crc_err  output  1  one-cycle pulse, CRC residual is non-zero
- crc_val  output  CRC_W  current CRC register

## Operation
- FSM states: IDLE, RUN, HOLD, ERR.
- IDLE: crc=0, run count=0, no stuff pending. On rx_start=1, go to RUN. This start edge is one-shot: reaching RUN again requires rx_start to return to 0.
- RUN, sample_en=1 with stuff pending (run count==STUFF_LEN):
  - rx_bit != last_bit: discard the bit, last_bit=rx_bit, run count=1, clear pending. No bit_valid pulse, no CRC update.
  - rx_bit == last_bit: stuff_err pulse, go to ERR.
- RUN, sample_en=1, no stuff pending: bit_out=rx_bit, bit_valid pulse, CRC update. Run count increments if rx_bit==last_bit, otherwise resets to 1. The first bit after entry (SOF) sets run count=1. last_bit=rx_bit.
- CRC update: crc <= {crc[CRC_W-2:0],1'b0} ^ ((rx_bit ^ crc[CRC_W-1]) ? CRC_POLY : 0).
- RUN, crc_chk=1: pulse crc_ok if crc==0, otherwise pulse crc_err; go to HOLD. If sample_en coincides with crc_chk, that bit is processed first and the verdict uses the updated CRC.
- HOLD and ERR: ignore sample_en and crc_chk. Go to IDLE when rx_start=0. crc_val is frozen.
- In any state, rx_start=0 forces IDLE on the next edge. A deassertion mid-frame produces no pulses.
- Same-cycle stuff violation and crc_chk: stuff_err wins; no crc_ok or crc_err pulse.

## Timing
- All outputs are registered. bit_valid, bit_out, stuff_err and the crc_val update appear 1 cycle after the sample_en edge.
- crc_ok and crc_err appear 1 cycle after crc_chk. Each pulse lasts exactly 1 cycle. At most one of stuff_err, crc_ok, crc_err is asserted per frame.
- rst=0 at a clock edge puts the FSM in IDLE. bit_out, bit_valid, stuff_err, crc_ok, crc_err = 0 and crc_val = 0, including mid-frame.
- sample_en strobes are at least 2 cycles apart. Behaviour with back-to-back strobes is undefined.

## Configuration
- CAN_RX_STUFF_CHECK_EN defined:
  - Stuff violation detection and the ERR state are built.
  - A violating stuff bit pulses stuff_err and goes to ERR, as above.
- Not defined:
  - A stuff-position bit is always discarded regardless of value, and run count resets to 1 with last_bit=rx_bit.
  - stuff_err is tied 0 and ERR is not built.

## Test plan
- Reset: hold rst=0 mid-frame after 3 bits -> all outputs 0 and crc_val=0 next cycle. FSM is in IDLE and needs a fresh rx_start edge.
- Stuff removal: rx_start=1, bits 0,0,0,0,0,1,0 -> 6 bit_valid pulses with bit_out=0 each; the 1 is dropped. crc_val=0; crc_chk then gives a crc_ok pulse.
- Stuff violation: rx_start=1, bits 0×6 -> stuff_err one cycle after the 6th strobe. A later crc_chk gives no pulse. rx_start=0 returns the FSM to IDLE. With the macro undefined, no stuff_err; the 6th bit is silently dropped.
- CRC fail: bits 0,1 then crc_chk -> crc_val=15'h4599, crc_err pulse, crc_ok stays 0.
- CRC pass: bits 0,1 then 15'h4599 MSB first (1,0,0,0,1,0,1,1,0,0,1,1,0,0,1), then crc_chk coincident with the last strobe -> crc_val=0 and crc_ok pulse one cycle later.
- Abort and one-shot: drop rx_start mid-frame -> IDLE, no pulses. Holding rx_start=1 after HOLD produces no new frame until rx_start toggles 0→1.
